// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven four-function decimal calculator controller.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   key_valid  - one-cycle strobe qualifying key_code
//   key_code   - 0-9 digit, A '+', B '-', C '*', D '/', E clear, F enter
//   disp_value - registered magnitude of the shown number (0..9999)
//   disp_neg   - registered sign of the shown number
//   err        - high while in the ERROR state
//   busy       - high while a division is running
//
// Configuration macro: CALC_DIV_EN enables the 14-cycle restoring divider,
// the DIVIDE state and the '/' key. Without it, '/' is ignored everywhere
// and busy is tied low.
module calc_ctrl #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [13:0] disp_value,
  output logic        disp_neg,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    ENTER_A, OP_WAIT, ENTER_B, DIVIDE, RESULT, ERROR
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_t;

  localparam logic [2:0]  MAXD  = 3'(MAX_DIGITS);
  localparam logic [13:0] LIMIT = 14'd9999;

  state_t      state;
  op_t         op;
  op_t         key_op;
  logic [13:0] a, b;
  logic [2:0]  cnt_a, cnt_b;

  logic        is_digit, is_op, is_clr, is_ent;
  logic [13:0] a_acc, b_acc;
  logic [14:0] sum;
  logic [27:0] prod;

  // Key decode; everything is qualified by key_valid.
  always_comb begin
    is_digit = key_valid && (key_code <= 4'd9);
`ifdef CALC_DIV_EN
    is_op    = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
`else
    is_op    = key_valid && (key_code >= 4'hA) && (key_code <= 4'hC);
`endif
    is_clr   = key_valid && (key_code == 4'hE);
    is_ent   = key_valid && (key_code == 4'hF);
    case (key_code)
      4'hA:    key_op = OP_ADD;
      4'hB:    key_op = OP_SUB;
      4'hC:    key_op = OP_MUL;
      default: key_op = OP_DIV;
    endcase
  end

  // Datapath helpers for digit accumulation and the arithmetic results.
  always_comb begin
    a_acc = 14'(a * 14'd10) + {10'd0, key_code};
    b_acc = 14'(b * 14'd10) + {10'd0, key_code};
    sum   = {1'b0, a} + {1'b0, b};
    prod  = 28'(a) * 28'(b);
  end

`ifdef CALC_DIV_EN
  logic [13:0] div_rem, div_quo;
  logic [3:0]  div_iter;
  logic [14:0] div_shift;
  logic [13:0] div_rem_nx, div_quo_nx;

  // One restoring step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits and record the quotient bit.
  always_comb begin
    div_shift = {div_rem, div_quo[13]};
    if (div_shift >= {1'b0, b}) begin
      div_rem_nx = 14'(div_shift - {1'b0, b});
      div_quo_nx = {div_quo[12:0], 1'b1};
    end else begin
      div_rem_nx = div_shift[13:0];
      div_quo_nx = {div_quo[12:0], 1'b0};
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENTER_A;
      op         <= OP_ADD;
      a          <= '0;
      b          <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      disp_value <= '0;
      disp_neg   <= 1'b0;
      err        <= 1'b0;
`ifdef CALC_DIV_EN
      busy       <= 1'b0;
      div_rem    <= '0;
      div_quo    <= '0;
      div_iter   <= '0;
`endif
    end else if (is_clr && state != DIVIDE) begin
      state      <= ENTER_A;
      op         <= OP_ADD;
      a          <= '0;
      b          <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      disp_value <= '0;
      disp_neg   <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          if (is_digit) begin
            if (cnt_a < MAXD) begin
              a          <= a_acc;
              cnt_a      <= cnt_a + 3'd1;
              disp_value <= a_acc;
            end
          end else if (is_op) begin
            op    <= key_op;
            state <= OP_WAIT;
          end
        end

        OP_WAIT: begin
          if (is_op) begin
            op <= key_op;
          end else if (is_digit) begin
            b          <= {10'd0, key_code};
            cnt_b      <= 3'd1;
            disp_value <= {10'd0, key_code};
            state      <= ENTER_B;
          end
        end

        ENTER_B: begin
          if (is_digit) begin
            if (cnt_b < MAXD) begin
              b          <= b_acc;
              cnt_b      <= cnt_b + 3'd1;
              disp_value <= b_acc;
            end
          end else if (is_ent) begin
            case (op)
              OP_ADD: begin
                if (sum > {1'b0, LIMIT}) begin
                  state      <= ERROR;
                  err        <= 1'b1;
                  disp_value <= '0;
                  disp_neg   <= 1'b0;
                end else begin
                  state      <= RESULT;
                  disp_value <= sum[13:0];
                  disp_neg   <= 1'b0;
                end
              end
              OP_SUB: begin
                state <= RESULT;
                if (a >= b) begin
                  disp_value <= a - b;
                  disp_neg   <= 1'b0;
                end else begin
                  disp_value <= b - a;
                  disp_neg   <= 1'b1;
                end
              end
              OP_MUL: begin
                if (prod > 28'(LIMIT)) begin
                  state      <= ERROR;
                  err        <= 1'b1;
                  disp_value <= '0;
                  disp_neg   <= 1'b0;
                end else begin
                  state      <= RESULT;
                  disp_value <= prod[13:0];
                  disp_neg   <= 1'b0;
                end
              end
              default: begin
`ifdef CALC_DIV_EN
                if (b == '0) begin
                  state      <= ERROR;
                  err        <= 1'b1;
                  disp_value <= '0;
                  disp_neg   <= 1'b0;
                end else begin
                  state      <= DIVIDE;
                  busy       <= 1'b1;
                  disp_value <= '0;
                  disp_neg   <= 1'b0;
                  div_rem    <= '0;
                  div_quo    <= a;
                  div_iter   <= '0;
                end
`endif
              end
            endcase
          end
        end

`ifdef CALC_DIV_EN
        // Keys, including clear, are ignored here; the 14th step lands
        // the quotient directly in the display register.
        DIVIDE: begin
          div_rem  <= div_rem_nx;
          div_quo  <= div_quo_nx;
          div_iter <= div_iter + 4'd1;
          if (div_iter == 4'd13) begin
            state      <= RESULT;
            busy       <= 1'b0;
            disp_value <= div_quo_nx;
            disp_neg   <= 1'b0;
          end
        end
`endif

        RESULT: begin
          if (is_digit) begin
            a          <= {10'd0, key_code};
            cnt_a      <= 3'd1;
            disp_value <= {10'd0, key_code};
            disp_neg   <= 1'b0;
            state      <= ENTER_A;
          end else if (is_op && !disp_neg) begin
            // Chain: the shown result becomes A, already "full" of digits.
            a     <= disp_value;
            cnt_a <= MAXD;
            op    <= key_op;
            state <= OP_WAIT;
          end
        end

        ERROR: begin
        end

        default: begin
          state <= ENTER_A;
        end
      endcase
    end
  end

endmodule
